pcie_dma_wr_arbiter: RTL and testbench
======================================

# pcie_dma_wr_arbiter

Round-robin scheduler that shares the single PCIe Avalon-MM burst write master (`pcie_bas_*`) among `NB_REQ` DMA requesters, such as per-queue packet writers and the tail-pointer writer. Each requester posts a burst descriptor (host address, length) and then streams flits. The arbiter grants one whole burst at a time, holds the address and burstcount stable for the burst, and honours `waitrequest`. It sits between the per-queue DMA engines and the PCIe hard-IP bursting master inside the PCIe top level.

## Interface
Parameters:
- `NB_REQ`, 4: number of requesters (2..16).
- `FLIT_W`, 512: data width in bits.
- `ADDR_W`, 64: host address width.
- `MAX_BURST`, 8: maximum flits per burst. `burstcount` width is `$clog2(MAX_BURST)+1`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NB_REQ  descriptor pending, one bit per requester.
- `req_addr`  in  NB_REQ×ADDR_W  host byte address, 64B aligned.
- `req_len`  in  NB_REQ×4  burst length in flits; legal range 1..MAX_BURST.
- `req_ack`  out  NB_REQ  one-cycle pulse when the descriptor is consumed.
- `flit_valid`  in  NB_REQ  flit data available.
- `flit_data`  in  NB_REQ×FLIT_W  flit payload.
- `flit_ready`  out  NB_REQ  flit consumed this cycle.
- `burst_done`  out  NB_REQ  one-cycle pulse on the last beat accepted.
- `bas_waitrequest`  in  1  slave stall.
- `bas_write`  out  1  write strobe.
- `bas_address`  out  ADDR_W  burst start address.
- `bas_burstcount`  out  $clog2(MAX_BURST)+1  burst length.
- `bas_writedata`  out  FLIT_W  beat data.
- `bas_byteenable`  out  FLIT_W/8  byte enables; all ones.
- `beat_cnt`  out  32  total accepted beats, wrapping.
- `stall_cnt`  out  32  cycles with `bas_write && bas_waitrequest`, wrapping.
- `bad_req_cnt`  out  32  descriptors dropped for illegal length.

## Operation
- State machine with two states, IDLE and BURST. The state register is `sel` (requester index), `len`, and `beats_left`.
- IDLE:
  - If any `req_valid` is set, grant the first set bit at or after `rr_ptr`, wrapping.
  - Pulse `req_ack[g]`, set `rr_ptr` to g+1 mod NB_REQ, and latch `bas_address` = `req_addr[g]`, `bas_burstcount` = `req_len[g]`, `beats_left` = `req_len[g]`.
  - If the length is legal, go to BURST.
  - If `req_len[g]` is 0 or greater than MAX_BURST, stay in IDLE, increment `bad_req_cnt`, and do not pulse `burst_done`. The `rr_ptr` update still applies.
- BURST:
  - `bas_write` = `flit_valid[sel]` and `bas_writedata` = `flit_data[sel]`.
  - `flit_ready[sel]` = `flit_valid[sel] && !bas_waitrequest`. All other `flit_ready` bits are 0.
  - A beat is accepted when `bas_write && !bas_waitrequest`. On each accepted beat, decrement `beats_left` and increment `beat_cnt`.
  - On acceptance with `beats_left` == 1: pulse `burst_done[sel]` and go to IDLE.
- `bas_address` and `bas_burstcount` stay constant from grant until the last beat. This holds even when `flit_valid` drops mid-burst; `bas_write` then deasserts and the burst resumes without reissuing.
- Requesters must drop or replace `req_valid` in the cycle after `req_ack`. A descriptor still valid after its ack is treated as a new request.
- `bas_byteenable` is constantly all ones.

## Timing
- Grant latency: 1 cycle. `req_valid` sampled in IDLE at edge N gives `req_ack` during N+1. The earliest `bas_write` is at N+1.
- Inter-burst bubble: exactly 1 IDLE cycle between bursts. Peak utilisation is L/(L+1) for length L.
- Fairness: a requester waits at most NB_REQ−1 bursts after raising `req_valid`.
- Registered outputs: `req_ack`, `bas_address`, `bas_burstcount`, and the counters.
- Combinational from `sel`, `flit_valid`, and `waitrequest`: `bas_write`, `bas_writedata`, `flit_ready`, and `burst_done`.
- Reset values:
  - state IDLE, `rr_ptr` 0, `sel` 0.
  - `bas_write` 0, `bas_address` 0, `bas_burstcount` 0.
  - `req_ack`, `flit_ready`, `burst_done` 0.
  - all counters 0.
- Reset asserted mid-burst abandons the burst immediately. There is no `burst_done` and no further beats.
- Counters wrap from 0xFFFFFFFF to 0. `beat_cnt` and `stall_cnt` may increment in the same cycle only if the spec permits it; it does not, because the two conditions are exclusive.

## Structure
- Shared package `pcie_arb_pkg`: the `arb_state_t` enum {IDLE, BURST}, the `MAX_BURST` default, and the `burstcount` width function.
- Sub-module `rr_arbiter`: a combinational rotating-priority encoder.
  - Inputs: `req[NB_REQ]`, `ptr`.
  - Outputs: `grant_idx`, `grant_valid`.
- Everything else lives in `pcie_dma_wr_arbiter`.

## Test plan
- Single burst: requester 0 sends len=2 at 0x1000, waitrequest 0.
  - Expect `req_ack[0]` 1 cycle later.
  - Expect two beats at address 0x1000, burstcount 2.
  - Expect `burst_done[0]` on beat 2, and `beat_cnt` = 2.
- Round robin: all 4 requesters valid, len=1 each, continuously.
  - Expect grant order 0,1,2,3,0.
  - Expect each burst followed by 1 idle cycle: 8 cycles per 4 beats.
- Waitrequest stall: len=4 with waitrequest high for 3 cycles on beat 2.
  - Expect address and burstcount held, data held.
  - Expect `stall_cnt` = 3 and `beat_cnt` = 4.
- flit_valid gap: `flit_valid` low for 2 cycles mid-burst (len=3).
  - Expect `bas_write` low for those 2 cycles.
  - Expect burstcount unchanged and done after beat 3.
- Illegal length: requester 2 sends len=0, then len=9.
  - Expect two acks and `bad_req_cnt` = 2.
  - Expect no `bas_write` and no `burst_done`.
- Reset mid-burst: assert `rst` after beat 1 of a len=8 burst.
  - Expect the next cycle to show `bas_write` 0, all counters 0, and `rr_ptr` 0.
  - Expect no `burst_done`.

Source files
------------

// File: rtl/pcie_arb_pkg.sv
// Shared definitions for the PCIe DMA write arbiter.
//   arb_state_t   : arbiter FSM states (IDLE, BURST)
//   MAX_BURST_DEF : default maximum flits per burst
//   bc_width()    : width of the Avalon burstcount field for a given max burst
package pcie_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int MAX_BURST_DEF = 8;

  // burstcount must be able to hold MAX_BURST itself, hence the +1.
  function automatic int bc_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/pcie_dma_wr_arbiter_rr_arbiter.sv
// Combinational rotating-priority encoder.
//   req         : request bits, one per requester
//   ptr         : index holding highest priority this cycle
//   grant_idx   : first set request at or after ptr, wrapping
//   grant_valid : any request set
module rr_arbiter
  import pcie_arb_pkg::*;
#(
  parameter int NB_REQ = 4
) (
  input  logic [NB_REQ-1:0]         req,
  input  logic [$clog2(NB_REQ)-1:0] ptr,
  output logic [$clog2(NB_REQ)-1:0] grant_idx,
  output logic                      grant_valid
);

  localparam int IDX_W = $clog2(NB_REQ);

  int idx;

  // Scan offsets from farthest to nearest so the last hit, which wins,
  // is the requester closest to ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NB_REQ;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pcie_dma_wr_arbiter.sv
// Round-robin scheduler sharing one PCIe Avalon-MM bursting write master
// among NB_REQ DMA requesters. One whole burst is granted at a time; the
// burst address and burstcount stay fixed until the last beat is accepted.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/addr/len    : per-requester burst descriptor
//   req_ack               : one-cycle pulse when a descriptor is consumed
//   flit_valid/data/ready : per-requester flit stream
//   burst_done            : one-cycle pulse on the last accepted beat
//   bas_*                 : Avalon-MM burst write master
//   beat_cnt, stall_cnt   : accepted beats, stalled write cycles (wrapping)
//   bad_req_cnt           : descriptors dropped for illegal length
module pcie_dma_wr_arbiter
  import pcie_arb_pkg::*;
#(
  parameter int NB_REQ    = 4,
  parameter int FLIT_W    = 512,
  parameter int ADDR_W    = 64,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NB_REQ-1:0]                  req_valid,
  input  logic [NB_REQ-1:0][ADDR_W-1:0]      req_addr,
  input  logic [NB_REQ-1:0][3:0]             req_len,
  output logic [NB_REQ-1:0]                  req_ack,
  input  logic [NB_REQ-1:0]                  flit_valid,
  input  logic [NB_REQ-1:0][FLIT_W-1:0]      flit_data,
  output logic [NB_REQ-1:0]                  flit_ready,
  output logic [NB_REQ-1:0]                  burst_done,
  input  logic                               bas_waitrequest,
  output logic                               bas_write,
  output logic [ADDR_W-1:0]                  bas_address,
  output logic [bc_width(MAX_BURST)-1:0]     bas_burstcount,
  output logic [FLIT_W-1:0]                  bas_writedata,
  output logic [FLIT_W/8-1:0]                bas_byteenable,
  output logic [31:0]                        beat_cnt,
  output logic [31:0]                        stall_cnt,
  output logic [31:0]                        bad_req_cnt
);

  localparam int BC_W  = bc_width(MAX_BURST);
  localparam int IDX_W = $clog2(NB_REQ);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic [BC_W-1:0]  beats_left;
  logic [3:0]       grant_len;
  logic             len_legal;
  logic             accept;

  rr_arbiter #(
    .NB_REQ (NB_REQ)
  ) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign grant_len      = req_len[grant_idx];
  assign len_legal      = (grant_len != 4'd0) && (int'(grant_len) <= MAX_BURST);
  assign ptr_nxt        = (int'(grant_idx) == NB_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
  assign bas_writedata  = flit_data[sel];
  assign bas_byteenable = '1;

  always_comb begin
    state_nxt  = state;
    bas_write  = 1'b0;
    accept     = 1'b0;
    flit_ready = '0;
    burst_done = '0;
    case (state)
      IDLE: begin
        // Illegal lengths are acked and dropped without leaving IDLE.
        if (grant_valid && len_legal) begin
          state_nxt = BURST;
        end
      end
      BURST: begin
        bas_write       = flit_valid[sel];
        accept          = bas_write && !bas_waitrequest;
        flit_ready[sel] = accept;
        if (accept && (beats_left == BC_W'(1))) begin
          burst_done[sel] = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      sel            <= '0;
      beats_left     <= '0;
      req_ack        <= '0;
      bas_address    <= '0;
      bas_burstcount <= '0;
      beat_cnt       <= 32'd0;
      stall_cnt      <= 32'd0;
      bad_req_cnt    <= 32'd0;
    end else begin
      state   <= state_nxt;
      req_ack <= '0;
      if ((state == IDLE) && grant_valid) begin
        req_ack[grant_idx] <= 1'b1;
        rr_ptr             <= ptr_nxt;
        sel                <= grant_idx;
        bas_address        <= req_addr[grant_idx];
        bas_burstcount     <= BC_W'(grant_len);
        beats_left         <= BC_W'(grant_len);
        if (!len_legal) begin
          bad_req_cnt <= bad_req_cnt + 32'd1;
        end
      end
      if (accept) begin
        beats_left <= beats_left - BC_W'(1);
        beat_cnt   <= beat_cnt + 32'd1;
      end
      // A stall needs bas_write, so it can never coincide with an accept.
      if (bas_write && bas_waitrequest) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pcie_dma_wr_arbiter.sv
// Testbench for pcie_dma_wr_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level reference model.
module tb_pcie_dma_wr_arbiter;

  localparam int NB  = 4;
  localparam int FW  = 512;
  localparam int AW  = 64;
  localparam int MB  = 8;
  localparam int BCW = $clog2(MB) + 1;

  logic                     clk;
  logic                     rst;
  logic [NB-1:0]            req_valid;
  logic [NB-1:0][AW-1:0]    req_addr;
  logic [NB-1:0][3:0]       req_len;
  logic [NB-1:0]            req_ack;
  logic [NB-1:0]            flit_valid;
  logic [NB-1:0][FW-1:0]    flit_data;
  logic [NB-1:0]            flit_ready;
  logic [NB-1:0]            burst_done;
  logic                     bas_waitrequest;
  logic                     bas_write;
  logic [AW-1:0]            bas_address;
  logic [BCW-1:0]           bas_burstcount;
  logic [FW-1:0]            bas_writedata;
  logic [FW/8-1:0]          bas_byteenable;
  logic [31:0]              beat_cnt;
  logic [31:0]              stall_cnt;
  logic [31:0]              bad_req_cnt;

  int n_tests;
  int n_fail;

  pcie_dma_wr_arbiter #(
    .NB_REQ    (NB),
    .FLIT_W    (FW),
    .ADDR_W    (AW),
    .MAX_BURST (MB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_len         (req_len),
    .req_ack         (req_ack),
    .flit_valid      (flit_valid),
    .flit_data       (flit_data),
    .flit_ready      (flit_ready),
    .burst_done      (burst_done),
    .bas_waitrequest (bas_waitrequest),
    .bas_write       (bas_write),
    .bas_address     (bas_address),
    .bas_burstcount  (bas_burstcount),
    .bas_writedata   (bas_writedata),
    .bas_byteenable  (bas_byteenable),
    .beat_cnt        (beat_cnt),
    .stall_cnt       (stall_cnt),
    .bad_req_cnt     (bad_req_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t reached, required finish before 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_valid       = '0;
    req_addr        = '0;
    req_len         = '0;
    flit_valid      = '0;
    flit_data       = '0;
    bas_waitrequest = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  function automatic logic [FW-1:0] rand_flit();
    logic [FW-1:0] v;
    for (int i = 0; i < FW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = {$urandom(), $urandom()};
    a[5:0] = 6'd0;
    return a;
  endfunction

  function automatic logic [NB-1:0] oh(input int i);
    return NB'(1) << i;
  endfunction

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = '1;
    req_len    = {4'd1, 4'd1, 4'd1, 4'd1};
    flit_valid = '1;
    next_cycle();
    next_cycle();
    sample();
    n_tests++; if (bas_write !== 1'b0) begin n_fail++; $display("FAIL reset_bas_write: got %b want 0", bas_write); end
    n_tests++; if (req_ack !== 4'b0) begin n_fail++; $display("FAIL reset_req_ack: got %b want 0", req_ack); end
    n_tests++; if (flit_ready !== 4'b0) begin n_fail++; $display("FAIL reset_flit_ready: got %b want 0", flit_ready); end
    n_tests++; if (burst_done !== 4'b0) begin n_fail++; $display("FAIL reset_burst_done: got %b want 0", burst_done); end
    n_tests++; if (bas_address !== 64'd0) begin n_fail++; $display("FAIL reset_address: got %h want 0", bas_address); end
    n_tests++; if (bas_burstcount !== 4'd0) begin n_fail++; $display("FAIL reset_burstcount: got %0d want 0", bas_burstcount); end
    n_tests++; if (beat_cnt !== 32'd0 || stall_cnt !== 32'd0 || bad_req_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", beat_cnt, stall_cnt, bad_req_cnt);
    end
    n_tests++; if (bas_byteenable !== {(FW/8){1'b1}}) begin n_fail++; $display("FAIL reset_byteenable: got %h want all ones", bas_byteenable); end
    apply_reset();
  endtask

  task automatic test_single_burst();
    logic [FW-1:0] d0, d1;
    apply_reset();
    d0 = rand_flit();
    d1 = rand_flit();
    req_valid[0] = 1'b1; req_addr[0] = 64'h1000; req_len[0] = 4'd2;
    flit_valid[0] = 1'b1; flit_data[0] = d0;
    sample();
    n_tests++; if (req_ack !== 4'b0) begin n_fail++; $display("FAIL single_ack_early: got %b want 0000", req_ack); end
    n_tests++; if (bas_write !== 1'b0) begin n_fail++; $display("FAIL single_write_early: got %b want 0", bas_write); end
    next_cycle();
    req_valid[0] = 1'b0;
    sample();
    n_tests++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want 0001", req_ack); end
    n_tests++; if (bas_write !== 1'b1) begin n_fail++; $display("FAIL single_beat1_write: got %b want 1", bas_write); end
    n_tests++; if (bas_address !== 64'h1000) begin n_fail++; $display("FAIL single_address: got %h want 1000", bas_address); end
    n_tests++; if (bas_burstcount !== 4'd2) begin n_fail++; $display("FAIL single_burstcount: got %0d want 2", bas_burstcount); end
    n_tests++; if (bas_writedata !== d0) begin n_fail++; $display("FAIL single_data1: got %h want %h", bas_writedata, d0); end
    n_tests++; if (flit_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready1: got %b want 0001", flit_ready); end
    n_tests++; if (burst_done !== 4'b0) begin n_fail++; $display("FAIL single_done_early: got %b want 0000", burst_done); end
    next_cycle();
    flit_data[0] = d1;
    sample();
    n_tests++; if (req_ack !== 4'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 0000", req_ack); end
    n_tests++; if (bas_write !== 1'b1 || bas_writedata !== d1) begin n_fail++; $display("FAIL single_beat2: got wr=%b data=%h want wr=1 data=%h", bas_write, bas_writedata, d1); end
    n_tests++; if (bas_address !== 64'h1000 || bas_burstcount !== 4'd2) begin n_fail++; $display("FAIL single_hold: got %h/%0d want 1000/2", bas_address, bas_burstcount); end
    n_tests++; if (burst_done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b want 0001", burst_done); end
    next_cycle();
    flit_valid[0] = 1'b0;
    sample();
    n_tests++; if (bas_write !== 1'b0 || burst_done !== 4'b0) begin n_fail++; $display("FAIL single_after: got wr=%b done=%b want 0/0000", bas_write, burst_done); end
    n_tests++; if (beat_cnt !== 32'd2) begin n_fail++; $display("FAIL single_beat_cnt: got %0d want 2", beat_cnt); end
    n_tests++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL single_stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_round_robin();
    int writes;
    int g;
    apply_reset();
    for (int i = 0; i < NB; i++) begin
      req_addr[i]  = 64'h4000 * (i + 1);
      req_len[i]   = 4'd1;
      flit_data[i] = rand_flit();
    end
    req_valid  = '1;
    flit_valid = '1;
    writes     = 0;
    sample();
    n_tests++; if (bas_write !== 1'b0) begin n_fail++; $display("FAIL rr_idle_start: got %b want 0", bas_write); end
    for (int k = 0; k < 9; k++) begin
      next_cycle();
      sample();
      if (k % 2 == 0) begin
        g = (k / 2) % NB;
        n_tests++; if (req_ack !== oh(g)) begin n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", k / 2, req_ack, oh(g)); end
        n_tests++; if (bas_write !== 1'b1 || burst_done !== oh(g) || flit_ready !== oh(g)) begin
          n_fail++; $display("FAIL rr_beat_%0d: got wr=%b done=%b rdy=%b want 1/%b/%b", k / 2, bas_write, burst_done, flit_ready, oh(g), oh(g));
        end
        n_tests++; if (bas_address !== 64'h4000 * (g + 1) || bas_writedata !== flit_data[g]) begin
          n_fail++; $display("FAIL rr_addr_data_%0d: got addr %h want %h", k / 2, bas_address, 64'h4000 * (g + 1));
        end
      end else begin
        n_tests++; if (bas_write !== 1'b0 || req_ack !== 4'b0) begin n_fail++; $display("FAIL rr_bubble_%0d: got wr=%b ack=%b want 0/0000", k, bas_write, req_ack); end
      end
      if (k < 8 && bas_write) writes++;
    end
    n_tests++; if (writes !== 4) begin n_fail++; $display("FAIL rr_utilisation: got %0d beats in 8 cycles want 4", writes); end
    n_tests++; if (beat_cnt !== 32'd4) begin n_fail++; $display("FAIL rr_beat_cnt: got %0d want 4", beat_cnt); end
  endtask

  task automatic test_waitrequest_stall();
    logic [FW-1:0] d [4];
    logic [AW-1:0] a;
    int bi, stalls;
    bit done;
    apply_reset();
    for (int i = 0; i < 4; i++) d[i] = rand_flit();
    a = rand_addr();
    req_valid[1] = 1'b1; req_addr[1] = a; req_len[1] = 4'd4; flit_valid[1] = 1'b1;
    bi = 0; stalls = 0; done = 1'b0;
    sample();
    next_cycle();
    req_valid[1] = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      flit_data[1]    = d[bi];
      bas_waitrequest = (bi == 1) && (stalls < 3);
      sample();
      n_tests++; if (bas_address !== a || bas_burstcount !== 4'd4) begin n_fail++; $display("FAIL stall_hold_c%0d: got %h/%0d want %h/4", c, bas_address, bas_burstcount, a); end
      n_tests++; if (bas_write !== 1'b1 || bas_writedata !== d[bi]) begin n_fail++; $display("FAIL stall_data_c%0d: got wr=%b want wr=1 beat %0d", c, bas_write, bi); end
      if (bas_waitrequest) begin
        stalls++;
        n_tests++; if (flit_ready !== 4'b0) begin n_fail++; $display("FAIL stall_ready_c%0d: got %b want 0000", c, flit_ready); end
      end
      if (flit_ready[1]) bi++;
      if (burst_done !== 4'b0) begin
        done = 1'b1;
        n_tests++; if (burst_done !== 4'b0010 || bi !== 4) begin n_fail++; $display("FAIL stall_done: got done=%b after %0d beats want 0010 after 4", burst_done, bi); end
      end
      next_cycle();
    end
    bas_waitrequest = 1'b0;
    flit_valid      = '0;
    n_tests++; if (!done) begin n_fail++; $display("FAIL stall_timeout: got no burst_done want done within 20 cycles"); end
    sample();
    n_tests++; if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
    n_tests++; if (beat_cnt !== 32'd4) begin n_fail++; $display("FAIL stall_beat_cnt: got %0d want 4", beat_cnt); end
  endtask

  task automatic test_flit_gap();
    logic [AW-1:0] a;
    int bi, gaps, cycles;
    bit done, fv;
    apply_reset();
    a = rand_addr();
    req_valid[3] = 1'b1; req_addr[3] = a; req_len[3] = 4'd3;
    bi = 0; gaps = 0; cycles = 0; done = 1'b0;
    sample();
    next_cycle();
    req_valid[3] = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      fv            = !((bi == 1) && (gaps < 2));
      flit_valid[3] = fv;
      flit_data[3]  = rand_flit();
      sample();
      cycles++;
      n_tests++; if (bas_write !== fv) begin n_fail++; $display("FAIL gap_write_c%0d: got %b want %b", c, bas_write, fv); end
      n_tests++; if (bas_burstcount !== 4'd3 || bas_address !== a) begin n_fail++; $display("FAIL gap_hold_c%0d: got %h/%0d want %h/3", c, bas_address, bas_burstcount, a); end
      if (!fv) gaps++;
      if (flit_ready[3]) bi++;
      if (burst_done !== 4'b0) begin
        done = 1'b1;
        n_tests++; if (burst_done !== 4'b1000 || bi !== 3) begin n_fail++; $display("FAIL gap_done: got done=%b after %0d beats want 1000 after 3", burst_done, bi); end
      end
      next_cycle();
    end
    flit_valid = '0;
    n_tests++; if (!done || cycles !== 5) begin n_fail++; $display("FAIL gap_length: got done=%b in %0d cycles want done in 5", done, cycles); end
    sample();
    n_tests++; if (beat_cnt !== 32'd3) begin n_fail++; $display("FAIL gap_beat_cnt: got %0d want 3", beat_cnt); end
  endtask

  task automatic test_illegal_len();
    logic [AW-1:0] a0, a1;
    bit any_write, any_done;
    apply_reset();
    a0 = rand_addr();
    a1 = rand_addr();
    any_write = 1'b0; any_done = 1'b0;
    flit_valid[2] = 1'b1; flit_data[2] = rand_flit();
    req_valid[2] = 1'b1; req_addr[2] = a0; req_len[2] = 4'd0;
    sample();
    any_write |= bas_write; any_done |= |burst_done;
    n_tests++; if (req_ack !== 4'b0) begin n_fail++; $display("FAIL bad_ack_early: got %b want 0000", req_ack); end
    next_cycle();
    req_addr[2] = a1; req_len[2] = 4'd9;
    sample();
    any_write |= bas_write; any_done |= |burst_done;
    n_tests++; if (req_ack !== 4'b0100) begin n_fail++; $display("FAIL bad_ack_len0: got %b want 0100", req_ack); end
    n_tests++; if (bas_address !== a0) begin n_fail++; $display("FAIL bad_addr_len0: got %h want %h", bas_address, a0); end
    next_cycle();
    req_valid[2] = 1'b0;
    sample();
    any_write |= bas_write; any_done |= |burst_done;
    n_tests++; if (req_ack !== 4'b0100) begin n_fail++; $display("FAIL bad_ack_len9: got %b want 0100", req_ack); end
    n_tests++; if (bas_burstcount !== 4'd9) begin n_fail++; $display("FAIL bad_burstcount: got %0d want 9", bas_burstcount); end
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      sample();
      any_write |= bas_write; any_done |= |burst_done;
    end
    n_tests++; if (req_ack !== 4'b0) begin n_fail++; $display("FAIL bad_ack_after: got %b want 0000", req_ack); end
    n_tests++; if (bad_req_cnt !== 32'd2) begin n_fail++; $display("FAIL bad_req_cnt: got %0d want 2", bad_req_cnt); end
    n_tests++; if (any_write || any_done) begin n_fail++; $display("FAIL bad_no_traffic: got write=%b done=%b want 0/0", any_write, any_done); end
    n_tests++; if (beat_cnt !== 32'd0) begin n_fail++; $display("FAIL bad_beat_cnt: got %0d want 0", beat_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req_valid[0] = 1'b1; req_addr[0] = rand_addr(); req_len[0] = 4'd8;
    flit_valid[0] = 1'b1; flit_data[0] = rand_flit();
    sample();
    next_cycle();
    req_valid[0] = 1'b0;
    sample();
    n_tests++; if (bas_write !== 1'b1) begin n_fail++; $display("FAIL rstmid_beat1: got %b want 1", bas_write); end
    next_cycle();
    rst = 1'b1;
    sample();
    next_cycle();
    sample();
    n_tests++; if (bas_write !== 1'b0 || burst_done !== 4'b0 || flit_ready !== 4'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got wr=%b done=%b rdy=%b want 0/0000/0000", bas_write, burst_done, flit_ready);
    end
    n_tests++; if (beat_cnt !== 32'd0 || stall_cnt !== 32'd0 || bad_req_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_counters: got %0d/%0d/%0d want 0/0/0", beat_cnt, stall_cnt, bad_req_cnt);
    end
    n_tests++; if (bas_address !== 64'd0 || bas_burstcount !== 4'd0) begin n_fail++; $display("FAIL rstmid_addr: got %h/%0d want 0/0", bas_address, bas_burstcount); end
    next_cycle();
    rst = 1'b0;
    // With the pointer back at 0, requester 0 must beat requester 1.
    req_valid = 4'b0011; req_len[0] = 4'd1; req_len[1] = 4'd1;
    sample();
    n_tests++; if (bas_write !== 1'b0 || burst_done !== 4'b0) begin n_fail++; $display("FAIL rstmid_quiet: got wr=%b done=%b want 0/0000", bas_write, burst_done); end
    next_cycle();
    req_valid = 4'b0000;
    sample();
    n_tests++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL rstmid_rr_ptr: got ack %b want 0001", req_ack); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    bit               pv [NB];
    logic [AW-1:0]    pa [NB];
    int               pl [NB];
    int               m_ptr, m_sel, m_left, m_bc, g, t;
    bit               m_busy, exp_wr, exp_acc;
    logic [AW-1:0]    m_addr;
    logic [NB-1:0]    m_ack, exp_rdy, exp_done;
    logic [31:0]      m_beats, m_stalls, m_bad;
    apply_reset();
    for (int i = 0; i < NB; i++) begin pv[i] = 1'b0; pa[i] = '0; pl[i] = 0; end
    m_ptr = 0; m_sel = 0; m_left = 0; m_bc = 0; m_busy = 1'b0;
    m_addr = '0; m_ack = '0; m_beats = 0; m_stalls = 0; m_bad = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (!pv[i] && $urandom_range(0, 3) == 0) begin
          pv[i] = 1'b1;
          pa[i] = rand_addr();
          t     = $urandom_range(0, 7);
          pl[i] = ($urandom_range(0, 9) == 0) ? ((t == 0) ? 0 : 8 + t) : $urandom_range(1, MB);
        end
        req_valid[i]  = pv[i];
        req_addr[i]   = pa[i];
        req_len[i]    = 4'(pl[i]);
        flit_valid[i] = ($urandom_range(0, 3) != 0);
        flit_data[i]  = rand_flit();
      end
      bas_waitrequest = ($urandom_range(0, 3) == 0);
      sample();
      exp_wr   = m_busy && flit_valid[m_sel];
      exp_acc  = exp_wr && !bas_waitrequest;
      exp_rdy  = exp_acc ? oh(m_sel) : '0;
      exp_done = (exp_acc && m_left == 1) ? oh(m_sel) : '0;
      n_tests++; if (req_ack !== m_ack) begin n_fail++; $display("FAIL rand_ack_c%0d: got %b want %b", c, req_ack, m_ack); end
      n_tests++; if (bas_address !== m_addr || bas_burstcount !== BCW'(m_bc)) begin
        n_fail++; $display("FAIL rand_desc_c%0d: got %h/%0d want %h/%0d", c, bas_address, bas_burstcount, m_addr, m_bc);
      end
      n_tests++; if (bas_write !== exp_wr || flit_ready !== exp_rdy || burst_done !== exp_done) begin
        n_fail++; $display("FAIL rand_hs_c%0d: got wr=%b rdy=%b done=%b want %b/%b/%b", c, bas_write, flit_ready, burst_done, exp_wr, exp_rdy, exp_done);
      end
      if (exp_wr) begin
        n_tests++; if (bas_writedata !== flit_data[m_sel]) begin n_fail++; $display("FAIL rand_data_c%0d: got data of wrong source, want requester %0d", c, m_sel); end
      end
      n_tests++; if (beat_cnt !== m_beats || stall_cnt !== m_stalls || bad_req_cnt !== m_bad) begin
        n_fail++; $display("FAIL rand_cnt_c%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c, beat_cnt, stall_cnt, bad_req_cnt, m_beats, m_stalls, m_bad);
      end
      // Reference model: what the coming clock edge does.
      m_ack = '0;
      if (exp_wr && bas_waitrequest) m_stalls++;
      if (m_busy) begin
        if (exp_acc) begin
          m_beats++;
          m_left--;
          if (m_left == 0) m_busy = 1'b0;
        end
      end else begin
        g = -1;
        for (int k = 0; k < NB; k++) begin
          int j;
          j = (m_ptr + k) % NB;
          if (pv[j] && g < 0) g = j;
        end
        if (g >= 0) begin
          m_ack  = oh(g);
          m_ptr  = (g + 1) % NB;
          m_addr = pa[g];
          m_bc   = pl[g];
          pv[g]  = 1'b0;
          if (pl[g] >= 1 && pl[g] <= MB) begin
            m_busy = 1'b1;
            m_sel  = g;
            m_left = pl[g];
          end else begin
            m_bad++;
          end
        end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    clear_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_waitrequest_stall();
    test_flit_gap();
    test_illegal_len();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
